// File: rtl/timer_seq_pkg.sv
// Shared register map, TCR/TSR bit positions and state encodings for the
// timer APB sequencer and its APB transfer engine.
package timer_seq_pkg;

    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;

    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_EN_BIT   = 4;
    localparam int TCR_DOWN_BIT = 5;
    localparam int TSR_OVF_BIT  = 0;
    localparam int TSR_UDF_BIT  = 1;

    localparam logic [7:0] TCR_LOAD_MASK = 8'(1 << TCR_LOAD_BIT);
    localparam logic [7:0] TCR_EN_MASK   = 8'(1 << TCR_EN_BIT);
    localparam logic [7:0] TSR_CLEAR     = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_TDR,
        ST_WR_LOAD,
        ST_WR_RUN,
        ST_WAIT,
        ST_RD_TSR,
        ST_CLR_TSR,
        ST_WR_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } xfer_phase_t;

    function automatic logic [1:0] tsr_flags(input logic [7:0] tsr);
        tsr_flags = {tsr[TSR_UDF_BIT], tsr[TSR_OVF_BIT]};
    endfunction

endpackage

// File: rtl/timer_apb_sequencer_if.sv
// APB bus between the sequencer (master) and the timer register slave.
interface timer_apb_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        pwdata;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_xfer.sv
// Single-transfer APB master engine: a req in idle runs SETUP then ACCESS until
// pready; done pulses the cycle after completion with rdata/slverr captured.
module apb_master_xfer
    import timer_seq_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              slverr,
    timer_apb_sequencer_if.master apb
);

    xfer_phase_t phase_r;
    logic        done_r;
    logic [7:0]  rdata_r;
    logic        slverr_r;

    // APB phase sequencing; address/direction/data are latched at SETUP so they stay stable to completion
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            phase_r     <= PH_IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= 8'h00;
            done_r      <= 1'b0;
            rdata_r     <= 8'h00;
            slverr_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (phase_r)
                PH_IDLE: begin
                    if (req) begin
                        apb.psel    <= 1'b1;
                        apb.penable <= 1'b0;
                        apb.pwrite  <= wr;
                        apb.paddr   <= addr;
                        apb.pwdata  <= wdata;
                        phase_r     <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    apb.penable <= 1'b1;
                    phase_r     <= PH_ACCESS;
                end
                PH_ACCESS: begin
                    if (apb.pready) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        done_r      <= 1'b1;
                        rdata_r     <= apb.prdata;
                        slverr_r    <= apb.pslverr;
                        phase_r     <= PH_IDLE;
                    end
                end
                default: begin
                    apb.psel    <= 1'b0;
                    apb.penable <= 1'b0;
                    phase_r     <= PH_IDLE;
                end
            endcase
        end
    end

    assign done   = done_r;
    assign rdata  = rdata_r;
    assign slverr = slverr_r;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Autonomous timer driver: programs TDR/TCR over APB, polls TSR for OVF/UDF,
// clears the flag and reloads or halts, reporting events and bus errors.
module timer_apb_sequencer
    import timer_seq_pkg::*;
#(
    parameter int POLL_GAP = 8,
    parameter int ADDR_W   = 8
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] cfg_tdr,
    input  logic [7:0] cfg_tcr,
    input  logic       auto_reload,
    timer_apb_sequencer_if.master apb,
    output logic       busy,
    output logic       evt,
    output logic [1:0] evt_flags,
    output logic [7:0] evt_cnt,
    output logic       err
);

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    seq_state_t        state_r, next_state_s;
    logic [7:0]        cfg_tdr_r, cfg_tcr_r;
    logic              auto_r, stop_pend_r, issued_r;
    logic [15:0]       gap_cnt_r;
    logic [1:0]        tsr_flags_r;
    logic              busy_r, evt_r, err_r;
    logic [1:0]        evt_flags_r;
    logic [7:0]        evt_cnt_r;

    logic              xfer_s, req_s, wr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [7:0]        wdata_s;
    logic              done_s, slverr_s;
    logic [7:0]        rdata_s;
    logic              start_ok_s, stop_now_s, xfer_ok_s, xfer_bad_s;

    assign start_ok_s = (state_r == ST_IDLE) && start;
    assign stop_now_s = stop_pend_r || stop;
    assign xfer_ok_s  = done_s && !slverr_s;
    assign xfer_bad_s = done_s && slverr_s;

    apb_master_xfer #(.ADDR_W(ADDR_W)) u_xfer (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (req_s),
        .wr      (wr_s),
        .addr    (addr_s),
        .wdata   (wdata_s),
        .done    (done_s),
        .rdata   (rdata_s),
        .slverr  (slverr_s),
        .apb     (apb)
    );

    // Sequencer state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state: transfer states advance only on done; a bus error aborts straight to idle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_WR_TDR;
                else       next_state_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (stop_now_s)                 next_state_s = ST_WR_HALT;
                else if (gap_cnt_r == GAP_LAST) next_state_s = ST_RD_TSR;
                else                            next_state_s = ST_WAIT;
            end
            default: begin
                if (!done_s)                          next_state_s = state_r;
                else if (slverr_s)                    next_state_s = ST_IDLE;
                else if (state_r == ST_WR_HALT)       next_state_s = ST_IDLE;
                else if (state_r == ST_CLR_TSR) begin
                    if (auto_r && !stop_now_s)        next_state_s = ST_WR_TDR;
                    else                              next_state_s = ST_WR_HALT;
                end
                else if (stop_now_s)                  next_state_s = ST_WR_HALT;
                else if (state_r == ST_WR_TDR)        next_state_s = ST_WR_LOAD;
                else if (state_r == ST_WR_LOAD)       next_state_s = ST_WR_RUN;
                else if (state_r == ST_WR_RUN)        next_state_s = ST_WAIT;
                else if (tsr_flags(rdata_s) != 2'b00) next_state_s = ST_CLR_TSR;
                else                                  next_state_s = ST_WAIT;
            end
        endcase
    end

    // Transfer decode per state; a request is raised once per state visit
    always_comb begin
        xfer_s  = 1'b1;
        wr_s    = 1'b1;
        addr_s  = ADDR_W'(ADDR_TCR);
        wdata_s = 8'h00;
        case (state_r)
            ST_WR_TDR: begin
                addr_s  = ADDR_W'(ADDR_TDR);
                wdata_s = cfg_tdr_r;
            end
            ST_WR_LOAD: wdata_s = (cfg_tcr_r | TCR_LOAD_MASK) & ~TCR_EN_MASK;
            ST_WR_RUN:  wdata_s = (cfg_tcr_r & ~TCR_LOAD_MASK) | TCR_EN_MASK;
            ST_RD_TSR: begin
                wr_s   = 1'b0;
                addr_s = ADDR_W'(ADDR_TSR);
            end
            ST_CLR_TSR: begin
                addr_s  = ADDR_W'(ADDR_TSR);
                wdata_s = TSR_CLEAR;
            end
            ST_WR_HALT: wdata_s = cfg_tcr_r & ~(TCR_LOAD_MASK | TCR_EN_MASK);
            default: begin
                xfer_s = 1'b0;
                wr_s   = 1'b0;
            end
        endcase
        req_s = xfer_s && !issued_r;
    end

    // Configuration capture, stop latch, poll timer, event and error bookkeeping
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cfg_tdr_r   <= 8'h00;
            cfg_tcr_r   <= 8'h00;
            auto_r      <= 1'b0;
            stop_pend_r <= 1'b0;
            issued_r    <= 1'b0;
            gap_cnt_r   <= 16'd0;
            tsr_flags_r <= 2'b00;
            busy_r      <= 1'b0;
            evt_r       <= 1'b0;
            evt_flags_r <= 2'b00;
            evt_cnt_r   <= 8'h00;
            err_r       <= 1'b0;
        end else begin
            busy_r    <= (next_state_s != ST_IDLE);
            evt_r     <= 1'b0;
            gap_cnt_r <= (state_r == ST_WAIT) ? gap_cnt_r + 16'd1 : 16'd0;

            if (done_s)     issued_r <= 1'b0;
            else if (req_s) issued_r <= 1'b1;

            if (start_ok_s) begin
                cfg_tdr_r <= cfg_tdr;
                cfg_tcr_r <= cfg_tcr;
                auto_r    <= auto_reload;
                evt_cnt_r <= 8'h00;
                err_r     <= 1'b0;
            end else if (xfer_bad_s) begin
                err_r <= 1'b1;
            end

            // a stop arriving with the accepted start still counts
            if (start_ok_s)                                 stop_pend_r <= stop;
            else if (next_state_s == ST_IDLE)               stop_pend_r <= 1'b0;
            else if (stop)                                  stop_pend_r <= 1'b1;

            if (state_r == ST_RD_TSR && xfer_ok_s) tsr_flags_r <= tsr_flags(rdata_s);

            if (state_r == ST_CLR_TSR && xfer_ok_s) begin
                evt_r       <= 1'b1;
                evt_cnt_r   <= evt_cnt_r + 8'd1;
                evt_flags_r <= tsr_flags_r;
            end
        end
    end

    assign busy      = busy_r;
    assign evt       = evt_r;
    assign evt_flags = evt_flags_r;
    assign evt_cnt   = evt_cnt_r;
    assign err       = err_r;

endmodule
